// File: rtl/prng_pkg.sv
// ============================================================================
// Module      : prng_pkg
// Description : Shared definitions for the prng sequencer: FSM state
//               encoding, Park-Miller multiplier/modulus and the seed table.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package prng_pkg;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_GUARD  = 3'd2,
        S_WAIT   = 3'd3,
        S_HAND   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    // Minimal-standard LCG constants
    localparam logic [31:0] A_DEF = 32'd16807;
    localparam logic [31:0] M_DEF = 32'd2147483647;

    // Seed table indexed by sel
    localparam logic [31:0] SEED0 = 32'd5;
    localparam logic [31:0] SEED1 = 32'd7;
    localparam logic [31:0] SEED2 = 32'd9;
    localparam logic [31:0] SEED3 = 32'd11;

endpackage : prng_pkg

`default_nettype wire

// File: rtl/prng_seq_ctrl.sv
// ============================================================================
// Module      : prng_seq_ctrl
// Description : Sequencer between system control, the prng core and the
//               parallel-to-serial converter. Selects a seed, launches the
//               prng, hands each result to p2s and chains it back as the next
//               seed until the requested count has been produced.
// Ports       : clk, rst           clock / synchronous active-high reset
//               start, sel, count  run request (sampled in IDLE only)
//               p2s_ready/load/data   handshake to the p2s converter
//               prng_start/cont/seed/m/a, prng_done/rand  prng core interface
//               seed, busy, run_done  status
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prng_seq_ctrl
    import prng_pkg::*;
#(
    parameter logic [31:0] SEED0_P = SEED0,
    parameter logic [31:0] SEED1_P = SEED1,
    parameter logic [31:0] SEED2_P = SEED2,
    parameter logic [31:0] SEED3_P = SEED3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic [7:0]  count,
    input  logic        p2s_ready,
    output logic        p2s_load,
    output logic [31:0] p2s_data,
    output logic        prng_start,
    output logic        prng_cont,
    output logic [31:0] prng_seed,
    output logic [31:0] prng_m,
    output logic [31:0] prng_a,
    input  logic        prng_done,
    input  logic [31:0] prng_rand,
    output logic [31:0] seed,
    output logic        busy,
    output logic        run_done
);

    state_t      state_q,     state_d;
    logic [31:0] seed_q,      seed_d;
    logic [31:0] prng_seed_q, prng_seed_d;
    logic [31:0] p2s_data_q,  p2s_data_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [31:0] sel_seed;

    // Seed table mux
    always_comb begin
        sel_seed = SEED0_P;
        case (sel)
            2'd0:    sel_seed = SEED0_P;
            2'd1:    sel_seed = SEED1_P;
            2'd2:    sel_seed = SEED2_P;
            default: sel_seed = SEED3_P;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            prng_seed_q <= '0;
            p2s_data_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            prng_seed_q <= prng_seed_d;
            p2s_data_q  <= p2s_data_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        prng_seed_d = prng_seed_q;
        p2s_data_d  = p2s_data_q;
        remaining_d = remaining_q;
        p2s_load    = 1'b0;
        prng_start  = 1'b0;
        run_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != 8'd0) begin
                        seed_d      = sel_seed;
                        prng_seed_d = sel_seed;
                        remaining_d = count;
                        state_d     = S_LAUNCH;
                    end else begin
                        state_d     = S_FIN;
                    end
                end
            end
            S_LAUNCH: begin
                prng_start = 1'b1;
                state_d    = S_GUARD;
            end
            // The core may still present the previous done for one cycle
            // after a restart; skipping this cycle avoids taking a stale word.
            S_GUARD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (prng_done) begin
                    p2s_data_d  = prng_rand;
                    prng_seed_d = prng_rand;
                    state_d     = S_HAND;
                end
            end
            // Single word in flight: hold here until p2s accepts it
            S_HAND: begin
                if (p2s_ready) begin
                    p2s_load = 1'b1;
                    if (remaining_q != 8'd0) begin
                        remaining_d = remaining_q - 8'd1;
                    end
                    if (remaining_q <= 8'd1) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_FIN: begin
                run_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign p2s_data  = p2s_data_q;
    assign prng_seed = prng_seed_q;
    assign seed      = seed_q;
    assign busy      = (state_q != S_IDLE);
    assign prng_cont = 1'b0;
    assign prng_m    = M_DEF;
    assign prng_a    = A_DEF;

endmodule : prng_seq_ctrl

`default_nettype wire

// File: tb/tb_prng_seq_ctrl.sv
// ============================================================================
// Module      : tb_prng_seq_ctrl
// Description : Self-checking bench for prng_seq_ctrl with a behavioural
//               prng core that holds done for one cycle after a restart.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prng_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [7:0]  count = 8'd0;
    logic        p2s_ready = 1'b1;
    logic        p2s_load;
    logic [31:0] p2s_data;
    logic        prng_start;
    logic        prng_cont;
    logic [31:0] prng_seed;
    logic [31:0] prng_m;
    logic [31:0] prng_a;
    logic        prng_done = 1'b0;
    logic [31:0] prng_rand = 32'd0;
    logic [31:0] seed;
    logic        busy;
    logic        run_done;

    prng_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sel        (sel),
        .count      (count),
        .p2s_ready  (p2s_ready),
        .p2s_load   (p2s_load),
        .p2s_data   (p2s_data),
        .prng_start (prng_start),
        .prng_cont  (prng_cont),
        .prng_seed  (prng_seed),
        .prng_m     (prng_m),
        .prng_a     (prng_a),
        .prng_done  (prng_done),
        .prng_rand  (prng_rand),
        .seed       (seed),
        .busy       (busy),
        .run_done   (run_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural prng core: one-cycle latency after the guard cycle, done
    // kept high until the cycle after the next start.
    localparam logic [63:0] C_A = 64'd16807;
    localparam logic [63:0] C_M = 64'd2147483647;
    logic [31:0] m_sd   = 32'd0;
    logic        m_hold = 1'b0;
    int          m_cnt  = 0;

    always @(negedge clk) begin
        if (rst) begin
            prng_done = 1'b0;
            m_hold    = 1'b0;
            m_cnt     = 0;
        end else if (prng_start) begin
            m_hold = 1'b1;
            m_cnt  = 1;
            m_sd   = prng_seed;
        end else if (m_hold) begin
            m_hold = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            prng_done = 1'b0;
            if (m_cnt == 0) begin
                prng_done = 1'b1;
                prng_rand = 32'(({32'd0, m_sd} * C_A) % C_M);
            end
        end
    end

    // Monitor
    logic [31:0] q_words[$];
    logic [31:0] q_seeds[$];
    int          n_done = 0;

    always @(negedge clk) begin
        if (p2s_load)   q_words.push_back(p2s_data);
        if (prng_start) q_seeds.push_back(prng_seed);
        if (run_done)   n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_words.delete();
        q_seeds.delete();
        n_done = 0;
    endtask

    task automatic launch(input logic [1:0] s, input logic [7:0] c);
        tick();
        start = 1'b1;
        sel   = s;
        count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (run_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
        tick();
    endtask

    function automatic logic [31:0] qget(input int idx, input logic [31:0] q[$]);
        if (idx < q.size()) return q[idx];
        return 32'hFFFF_FFFF;
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  cnt;
        logic [31:0] exp_seed;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int viol;
        bit seen;

        vecs[0] = '{2'd0, 8'd1, 32'd5,  32'd84035,  32'd0};
        vecs[1] = '{2'd0, 8'd2, 32'd5,  32'd84035,  32'd1412376245};
        vecs[2] = '{2'd1, 8'd1, 32'd7,  32'd117649, 32'd0};
        vecs[3] = '{2'd2, 8'd1, 32'd9,  32'd151263, 32'd0};
        vecs[4] = '{2'd3, 8'd1, 32'd11, 32'd184877, 32'd0};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_p2s_load",   p2s_load,   1'b0);
        chk("rst_prng_start", prng_start, 1'b0);
        chk("rst_run_done",   run_done,   1'b0);
        chk("rst_p2s_data",   p2s_data,   32'd0);
        chk("rst_prng_seed",  prng_seed,  32'd0);
        chk("rst_seed",       seed,       32'd0);
        chk("prng_m",         prng_m,     32'd2147483647);
        chk("prng_a",         prng_a,     32'd16807);
        chk("prng_cont",      prng_cont,  1'b0);
        tick();
        rst = 1'b0;

        // Table-driven runs
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            p2s_ready = 1'b1;
            launch(vecs[v].sel, vecs[v].cnt);
            @(negedge clk);
            chk($sformatf("v%0d_start_latency", v), prng_start, 1'b1);
            wait_done($sformatf("v%0d", v));
            chk($sformatf("v%0d_seed", v),     seed, vecs[v].exp_seed);
            chk($sformatf("v%0d_seed0", v),    qget(0, q_seeds), vecs[v].exp_seed);
            chk($sformatf("v%0d_n_loads", v),  q_words.size(), vecs[v].cnt);
            chk($sformatf("v%0d_n_starts", v), q_seeds.size(), vecs[v].cnt);
            chk($sformatf("v%0d_n_done", v),   n_done, 1);
            chk($sformatf("v%0d_w0", v),       qget(0, q_words), vecs[v].exp_w0);
            if (vecs[v].cnt == 8'd2) begin
                chk($sformatf("v%0d_w1", v),    qget(1, q_words), vecs[v].exp_w1);
                chk($sformatf("v%0d_seed1", v), qget(1, q_seeds), vecs[v].exp_w0);
            end
            chk($sformatf("v%0d_idle", v), busy, 1'b0);
        end

        // Backpressure: p2s_ready low for 20 cycles after the word is captured
        clear_mon();
        p2s_ready = 1'b0;
        launch(2'd1, 8'd1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (p2s_data == 32'd117649) begin
                seen = 1;
                break;
            end
        end
        chk("bp_captured", seen, 1'b1);
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p2s_load || prng_start || p2s_data != 32'd117649) viol++;
        end
        chk("bp_hold_violations", viol, 0);
        tick();
        p2s_ready = 1'b1;
        #1;
        chk("bp_load_on_ready", p2s_load, 1'b1);
        wait_done("bp");
        chk("bp_n_loads",  q_words.size(), 1);
        chk("bp_n_starts", q_seeds.size(), 1);
        chk("bp_w0",       qget(0, q_words), 32'd117649);

        // start pulsed while busy is ignored
        clear_mon();
        launch(2'd0, 8'd2);
        repeat (3) tick();
        start = 1'b1;
        sel   = 2'd3;
        count = 8'd5;
        tick();
        start = 1'b0;
        wait_done("busy_start");
        repeat (5) tick();
        chk("busy_n_loads", q_words.size(), 2);
        chk("busy_seed",    seed, 32'd5);
        chk("busy_w1",      qget(1, q_words), 32'd1412376245);
        chk("busy_n_done",  n_done, 1);

        // count == 0: run_done next cycle, no prng_start
        clear_mon();
        launch(2'd2, 8'd0);
        @(negedge clk);
        chk("c0_run_done", run_done, 1'b1);
        repeat (5) tick();
        chk("c0_n_starts", q_seeds.size(), 0);
        chk("c0_n_done",   n_done, 1);
        chk("c0_idle",     busy, 1'b0);

        // Reset asserted while waiting on the core
        clear_mon();
        launch(2'd0, 8'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rw_busy",       busy,       1'b0);
        chk("rw_p2s_data",   p2s_data,   32'd0);
        chk("rw_prng_seed",  prng_seed,  32'd0);
        chk("rw_seed",       seed,       32'd0);
        chk("rw_p2s_load",   p2s_load,   1'b0);
        chk("rw_prng_start", prng_start, 1'b0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rw_n_done",  n_done, 0);
        chk("rw_n_loads", q_words.size(), 0);

        // Fresh run after the abort
        clear_mon();
        launch(2'd1, 8'd1);
        wait_done("post_rst");
        chk("post_rst_seed", seed, 32'd7);
        chk("post_rst_w0",   qget(0, q_words), 32'd117649);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_prng_seq_ctrl

`default_nettype wire
